// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and the general register file.
// Mirrors the RegNum / RegAddrBus / enable definitions used across the pipeline.
package wb_regfile_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int REG_NUM        = 32;
  localparam int REG_NUM_LOG2   = 5;

  localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = 5'b00000;
  localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = 32'h0000_0000;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/wb_regfile_core.sv
// 32x32 register array with one write port and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward the in-flight write to the read ports.
module wb_regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_NUM_LOG2,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              hit1;
  logic              hit2;

  // NOTE: the array is reset because software expects every register to read
  // zero after reset; r0 is never written, so it stays zero without a special case.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= ZERO_WORD;
    end else if (we_i == WRITE_ENABLE && waddr_i != NOP_REG_ADDR) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // r0 never hits: the zero-address rule below overrides the forward.
  assign hit1 = (we_i == WRITE_ENABLE) && (waddr_i == raddr1_i);
  assign hit2 = (we_i == WRITE_ENABLE) && (waddr_i == raddr2_i);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // NOTE: each output is assigned a default first so no path leaves it unassigned
  // (which would infer a latch); later assignments take priority.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (hit1) rdata1_o = wdata_i;
    if (rst == RST_ENABLE || re1_i == READ_DISABLE || raddr1_i == NOP_REG_ADDR)
      rdata1_o = ZERO_WORD;
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (hit2) rdata2_o = wdata_i;
    if (rst == RST_ENABLE || re2_i == READ_DISABLE || raddr2_i == NOP_REG_ADDR)
      rdata2_o = ZERO_WORD;
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB pipeline register feeding the general register file.
// Define REGFILE_BYPASS_EN to make a result readable one cycle earlier (at N+1).
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_NUM_LOG2,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o
);

  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic [ADDR_W-1:0] wb_wd_q,    wb_wd_d;
  logic              wb_wreg_q,  wb_wreg_d;

  // Flush outranks stall so a killed instruction can never be held in WB.
  always_comb begin
    wb_wdata_d = wb_wdata_q;
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    if (flush) begin
      wb_wdata_d = ZERO_WORD;
      wb_wd_d    = NOP_REG_ADDR;
      wb_wreg_d  = WRITE_DISABLE;
    end else if (!stall) begin
      wb_wdata_d = wdata_i;
      wb_wd_d    = wd_i;
      wb_wreg_d  = wreg_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wb_wdata_q <= ZERO_WORD;
      wb_wd_q    <= NOP_REG_ADDR;
      wb_wreg_q  <= WRITE_DISABLE;
    end else begin
      wb_wdata_q <= wb_wdata_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
    end
  end

  // Gated so the hazard unit sees zeros for the whole reset cycle, not just after the edge.
  assign wb_wdata_o = (rst == RST_ENABLE) ? ZERO_WORD     : wb_wdata_q;
  assign wb_wd_o    = (rst == RST_ENABLE) ? NOP_REG_ADDR  : wb_wd_q;
  assign wb_wreg_o  = (rst == RST_ENABLE) ? WRITE_DISABLE : wb_wreg_q;

  wb_regfile_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_wreg_q),
    .waddr_i  (wb_wd_q),
    .wdata_i  (wb_wdata_q),
    .re1_i    (re1),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .re2_i    (re2),
    .raddr2_i (raddr2),
    .rdata2_o (rdata2)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized run
// against an architectural model (register array + one in-flight write-back slot).
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] wb_wdata_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Architectural model: committed registers plus the result waiting in WB.
  logic [31:0] mdl_regs [32];
  logic [31:0] m_wdata;
  logic [4:0]  m_wd;
  logic        m_wreg;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .wdata_i    (wdata_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .wb_wdata_o (wb_wdata_o),
    .wb_wd_o    (wb_wd_o),
    .wb_wreg_o  (wb_wreg_o)
  );

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
      m_wdata = 32'h0; m_wd = 5'd0; m_wreg = 1'b0;
    end else begin
      if (m_wreg && m_wd != 5'd0) mdl_regs[m_wd] = m_wdata;
      if (flush) begin
        m_wdata = 32'h0; m_wd = 5'd0; m_wreg = 1'b0;
      end else if (!stall) begin
        m_wdata = wdata_i; m_wd = wd_i; m_wreg = wreg_i;
      end
    end
  endtask

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (BYPASS && m_wreg && m_wd == a) return m_wdata;
    return mdl_regs[a];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wreg_i = 1'b1; wd_i = 5'd9; wdata_i = $urandom;
    re1 = 1'b1; re2 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      raddr1 = 5'($urandom); raddr2 = 5'($urandom);
      step();
      tests_run++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata1, rdata2);
      end
      tests_run++;
      if (wb_wreg_o !== 1'b0 || wb_wd_o !== 5'd0 || wb_wdata_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_wb: got wreg=%b wd=%0d wdata=%h expected all 0",
                 wb_wreg_o, wb_wd_o, wb_wdata_o);
      end
    end
    rst = 1'b0; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      tests_run++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL post_reset_r%0d: got %h/%h expected 0/0", a, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_latency();
    wreg_i = 1'b1; wd_i = 5'd5; wdata_i = 32'hDEAD_BEEF;
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    tests_run++;
    if (rdata1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL latency_c0: got %h expected %h", rdata1, 32'h0);
    end
    step();
    wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
    #1;
    tests_run++;
    if (rdata1 !== (BYPASS ? 32'hDEAD_BEEF : 32'h0) || wb_wd_o !== 5'd5) begin
      tests_failed++;
      $display("FAIL latency_c1: got rdata1=%h wb_wd=%0d expected %h/5",
               rdata1, wb_wd_o, BYPASS ? 32'hDEAD_BEEF : 32'h0);
    end
    step();
    tests_run++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL latency_c2: got %h expected %h", rdata1, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_r0();
    wreg_i = 1'b1; wd_i = 5'd0; wdata_i = 32'h1234;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) wreg_i = 1'b0;
      #1;
      tests_run++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL r0_c%0d: got %h/%h expected 0/0", c, rdata1, rdata2);
      end
      step();
    end
  endtask

  task automatic test_stall();
    wreg_i = 1'b1; wd_i = 5'd3; wdata_i = 32'h11;
    step();
    stall = 1'b1; wd_i = 5'd6; wdata_i = 32'h55;
    re2 = 1'b1; raddr2 = 5'd6;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (wb_wd_o !== 5'd3 || wb_wdata_o !== 32'h11 || wb_wreg_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold: got wd=%0d wdata=%h wreg=%b expected 3/00000011/1",
                 wb_wd_o, wb_wdata_o, wb_wreg_o);
      end
      tests_run++;
      if (rdata2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL stall_r6: got %h expected %h", rdata2, 32'h0);
      end
    end
    stall = 1'b0;
    step();
    tests_run++;
    if (wb_wd_o !== 5'd6 || wb_wdata_o !== 32'h55) begin
      tests_failed++;
      $display("FAIL stall_release: got wd=%0d wdata=%h expected 6/00000055", wb_wd_o, wb_wdata_o);
    end
    wreg_i = 1'b0;
    step();
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    tests_run++;
    if (rdata2 !== 32'h55 || rdata1 !== 32'h11) begin
      tests_failed++;
      $display("FAIL stall_commit: got r6=%h r3=%h expected 00000055/00000011", rdata2, rdata1);
    end
  endtask

  task automatic test_flush();
    wreg_i = 1'b1; wd_i = 5'd2; wdata_i = 32'h22;
    step();
    flush = 1'b1; stall = 1'b1; wd_i = 5'd7; wdata_i = 32'h77;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (wb_wreg_o !== 1'b0 || wb_wd_o !== 5'd0 || wb_wdata_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL flush_wb: got wreg=%b wd=%0d wdata=%h expected all 0",
                 wb_wreg_o, wb_wd_o, wb_wdata_o);
      end
    end
    flush = 1'b0; stall = 1'b0; wreg_i = 1'b0;
    step(); step();
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd2;
    #1;
    tests_run++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h22) begin
      tests_failed++;
      $display("FAIL flush_regs: got r7=%h r2=%h expected 00000000/00000022", rdata1, rdata2);
    end
  endtask

  task automatic test_read_enable();
    wreg_i = 1'b0;
    re1 = 1'b0; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    tests_run++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL read_enable: got %h/%h expected 00000000/deadbeef", rdata1, rdata2);
    end
    re1 = 1'b1;
    #1;
    tests_run++;
    if (rdata1 !== rdata2 || rdata1 !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL same_addr: got %h/%h expected deadbeef/deadbeef", rdata1, rdata2);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 79) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      wreg_i  = ($urandom_range(0, 3) != 0);
      wd_i    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wdata_i = $urandom;
      re1     = ($urandom_range(0, 7) != 0);
      re2     = ($urandom_range(0, 7) != 0);
      raddr1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      raddr2  = ($urandom_range(0, 1) == 0) ? raddr1 : 5'($urandom_range(0, 7));
      #1;
      e1 = exp_read(re1, raddr1);
      e2 = exp_read(re2, raddr2);
      tests_run++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        tests_failed++;
        $display("FAIL rand_read c%0d a=%0d/%0d: got %h/%h expected %h/%h",
                 c, raddr1, raddr2, rdata1, rdata2, e1, e2);
      end
      tests_run++;
      if (wb_wreg_o !== (rst ? 1'b0 : m_wreg) || wb_wd_o !== (rst ? 5'd0 : m_wd) ||
          wb_wdata_o !== (rst ? 32'h0 : m_wdata)) begin
        tests_failed++;
        $display("FAIL rand_wb c%0d: got %b/%0d/%h expected %b/%0d/%h", c,
                 wb_wreg_o, wb_wd_o, wb_wdata_o, m_wreg, m_wd, m_wdata);
      end
      step();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wdata_i = 32'h0; wd_i = 5'd0; wreg_i = 1'b0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
    test_reset();
    test_write_latency();
    test_r0();
    test_stall();
    test_flush();
    test_read_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
